// File: rtl/sm4_dec_iter.sv
// rtl/sm4_dec_iter.sv - iterative SM4 block decryptor with a 32-entry round-key file
//
// Purpose:
//   Takes one 128-bit ciphertext block, runs ROUNDS_PER_CYCLE SM4 rounds per
//   clock using round keys in reverse order (rk31..rk0), applies the final
//   word reversal and presents the 128-bit plaintext.
//
// Parameters:
//   ROUNDS_PER_CYCLE  rounds unrolled per clock: 1, 2 or 4 (others rejected at build time)
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rk_wr_en/addr/data  round-key write port (rk0 = first encryption round key)
//   key_wr_err          one-cycle pulse when a key write is dropped because the block is busy
//   in_valid/in_ready   ciphertext handshake, ct_in word X0 in [127:96]
//   out_valid/out_ready plaintext handshake, pt_out word 0 in [127:96]
//   busy                high while a block is being processed or waiting for output
//
// Optional feature macro: SM4_ENC_MODE_EN
//   Adds input enc_mode, sampled on the accept edge; 1 = encrypt (rk0..rk31),
//   0 = decrypt (rk31..rk0).
module sm4_dec_iter #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rk_wr_en,
    input  logic [4:0]   rk_wr_addr,
    input  logic [31:0]  rk_wr_data,
    output logic         key_wr_err,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ct_in,
`ifdef SM4_ENC_MODE_EN
    input  logic         enc_mode,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] pt_out,
    output logic         busy
);

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4)) begin : g_bad_rounds
        $error("sm4_dec_iter: ROUNDS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [0:255][7:0] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Round transform T: bytewise S-box then linear diffusion L.
    function automatic logic [31:0] sm4_t(input logic [31:0] a);
        logic [31:0] b;
        b = {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
        return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]}
                 ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
    endfunction

    // One round: {X0,X1,X2,X3} -> {X1,X2,X3,X0^T(X1^X2^X3^rk)}
    function automatic logic [127:0] sm4_round(input logic [127:0] x, input logic [31:0] rk);
        return {x[95:0], x[127:96] ^ sm4_t(x[95:64] ^ x[63:32] ^ x[31:0] ^ rk)};
    endfunction

    state_t       r_state;
    state_t       w_state_nxt;
    logic [31:0]  r_rk [32];
    logic [127:0] r_x;
    logic [4:0]   r_cnt;
    logic [127:0] r_pt;
    logic         r_key_wr_err;
    logic         w_enc;
    logic         w_last;
    logic [127:0] w_stage [ROUNDS_PER_CYCLE+1];

`ifdef SM4_ENC_MODE_EN
    logic r_enc;
    assign w_enc = r_enc;
`else
    assign w_enc = 1'b0;
`endif

    // Counter is the global index of the first round applied this clock; the
    // last RUN clock is the one whose final round is round 31.
    assign w_last = (r_cnt == 5'(32 - ROUNDS_PER_CYCLE));

    assign w_stage[0] = r_x;
    for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_round
        logic [4:0]  w_j;
        logic [31:0] w_rk;
        assign w_j  = r_cnt + 5'(g);
        assign w_rk = w_enc ? r_rk[w_j] : r_rk[5'd31 - w_j];
        assign w_stage[g+1] = sm4_round(w_stage[g], w_rk);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        busy        = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) r_rk[i] <= '0;
            r_x          <= '0;
            r_cnt        <= '0;
            r_pt         <= '0;
            r_key_wr_err <= 1'b0;
`ifdef SM4_ENC_MODE_EN
            r_enc        <= 1'b0;
`endif
        end else begin
            // Keys only change in IDLE, so a block never sees a half-updated schedule.
            r_key_wr_err <= rk_wr_en && (r_state != S_IDLE);
            if (rk_wr_en && (r_state == S_IDLE)) begin
                r_rk[rk_wr_addr] <= rk_wr_data;
            end
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_x   <= ct_in;
                        r_cnt <= '0;
`ifdef SM4_ENC_MODE_EN
                        r_enc <= enc_mode;
`endif
                    end
                end
                S_RUN: begin
                    r_x   <= w_stage[ROUNDS_PER_CYCLE];
                    r_cnt <= r_cnt + 5'(ROUNDS_PER_CYCLE);
                    if (w_last) begin
                        // Final word reversal: {X35,X34,X33,X32}
                        r_pt <= {w_stage[ROUNDS_PER_CYCLE][31:0],
                                 w_stage[ROUNDS_PER_CYCLE][63:32],
                                 w_stage[ROUNDS_PER_CYCLE][95:64],
                                 w_stage[ROUNDS_PER_CYCLE][127:96]};
                    end
                end
                default: ;
            endcase
        end
    end

    assign pt_out     = r_pt;
    assign key_wr_err = r_key_wr_err;

endmodule
